// File: rtl/frame_pkg.sv
// ============================================================================
//  Module      : frame_pkg
//  Description : Shared frame geometry (80x60 pixel frame RAMs) and the state
//                encoding of the frame pair scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package frame_pkg;

  // Words per frame RAM (80 x 60 pixels), address width and word width.
  localparam int DEPTH = 4800;
  localparam int AW    = 14;
  localparam int DW    = 25;

  // Scheduler state encoding.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SCAN  = 3'd1;
  localparam logic [2:0] ST_DRAIN = 3'd2;
  localparam logic [2:0] ST_COPY  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // Every state except IDLE counts as an operation in progress.
  function automatic logic state_is_busy(input logic [2:0] s);
    return (s != ST_IDLE);
  endfunction

endpackage

`default_nettype wire

// File: rtl/frame_pair_scheduler_if.sv
// ============================================================================
//  Module      : frame_pair_scheduler_if
//  Description : Bus bundle between the frame pair scheduler and its
//                environment: shared combinational read port of the ref/act
//                frame RAMs, ref RAM write port, and the pixel-pair stream.
//  Ports       : rd_addr/ref_q/act_q        - RAM read (data valid same cycle)
//                ref_wr_addr/_data/_en      - ref RAM write
//                pix_valid/pix_ready        - pair stream handshake
//                pix_ref/pix_act/pix_addr/pix_last - pair payload
//  Modports    : master = scheduler side, slave = RAMs + downstream side
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface frame_pair_scheduler_if #(
  parameter int AW = frame_pkg::AW,
  parameter int DW = frame_pkg::DW
) ();

  logic [AW-1:0] rd_addr;
  logic [DW-1:0] ref_q;
  logic [DW-1:0] act_q;

  logic [AW-1:0] ref_wr_addr;
  logic [DW-1:0] ref_wr_data;
  logic          ref_wr_en;

  logic          pix_valid;
  logic          pix_ready;
  logic [DW-1:0] pix_ref;
  logic [DW-1:0] pix_act;
  logic [AW-1:0] pix_addr;
  logic          pix_last;

  modport master (
    output rd_addr,
    input  ref_q,
    input  act_q,
    output ref_wr_addr,
    output ref_wr_data,
    output ref_wr_en,
    output pix_valid,
    input  pix_ready,
    output pix_ref,
    output pix_act,
    output pix_addr,
    output pix_last
  );

  modport slave (
    input  rd_addr,
    output ref_q,
    output act_q,
    input  ref_wr_addr,
    input  ref_wr_data,
    input  ref_wr_en,
    input  pix_valid,
    output pix_ready,
    input  pix_ref,
    input  pix_act,
    input  pix_addr,
    input  pix_last
  );

endinterface

`default_nettype wire

// File: rtl/frame_pair_scheduler.sv
// ============================================================================
//  Module      : frame_pair_scheduler
//  Description : Scans a reference and an actual frame RAM in lock-step and
//                streams {ref, act, addr} pairs downstream with a ready/valid
//                handshake. Optionally copies the actual frame into the
//                reference frame once the scan has drained.
//  Ports       : clk     - single clock, posedge
//                rst     - synchronous reset, active-high
//                start   - pulse, begins a scan when idle
//                upd_en  - sampled with start, request act->ref copy
//                abort   - terminate any operation, back to IDLE
//                busy    - high in every state except IDLE
//                done    - one-cycle completion pulse
//                bus     - RAM ports and pixel-pair stream (master side)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module frame_pair_scheduler #(
  parameter int DEPTH = frame_pkg::DEPTH,
  parameter int AW    = frame_pkg::AW,
  parameter int DW    = frame_pkg::DW
) (
  input  wire                    clk,
  input  wire                    rst,
  input  wire                    start,
  input  wire                    upd_en,
  input  wire                    abort,
  output logic                   busy,
  output logic                   done,
  frame_pair_scheduler_if.master bus
);

  import frame_pkg::*;

  localparam logic [AW-1:0] c_LAST = AW'(DEPTH - 1);

  logic [2:0]    r_state;
  logic [AW-1:0] r_cnt;
  logic          r_upd;
  logic [DW-1:0] r_pix_ref;
  logic [DW-1:0] r_pix_act;
  logic [AW-1:0] r_pix_addr;
  logic          r_pix_valid;
  logic          r_pix_last;

  logic          w_load;
  logic          w_at_last;
  logic          w_copy_wr;

  // The output register takes a new pair whenever it is empty or the current
  // pair is being accepted in this very cycle.
  assign w_load    = (r_state == ST_SCAN) && (!r_pix_valid || bus.pix_ready);
  assign w_at_last = (r_cnt == c_LAST);

  // The write strobe is cut combinationally by rst/abort so that the word
  // addressed in the terminating cycle is not written: everything below the
  // current index is updated, everything from it upward is untouched.
  assign w_copy_wr = (r_state == ST_COPY) && !abort && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_upd       <= 1'b0;
      r_pix_ref   <= '0;
      r_pix_act   <= '0;
      r_pix_addr  <= '0;
      r_pix_valid <= 1'b0;
      r_pix_last  <= 1'b0;
    end else if (abort) begin
      r_state     <= ST_IDLE;
      r_pix_valid <= 1'b0;
      r_pix_last  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_upd   <= upd_en;
            r_cnt   <= '0;
            r_state <= ST_SCAN;
          end
        end

        ST_SCAN: begin
          if (w_load) begin
            r_pix_ref   <= bus.ref_q;
            r_pix_act   <= bus.act_q;
            r_pix_addr  <= r_cnt;
            r_pix_valid <= 1'b1;
            r_pix_last  <= w_at_last;
            // The counter parks on the last address rather than wrapping.
            if (w_at_last) begin
              r_state <= ST_DRAIN;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end

        ST_DRAIN: begin
          // The last pair is held until the downstream side takes it.
          if (bus.pix_ready) begin
            r_pix_valid <= 1'b0;
            r_pix_last  <= 1'b0;
            if (r_upd) begin
              r_cnt   <= '0;
              r_state <= ST_COPY;
            end else begin
              r_state <= ST_DONE;
            end
          end
        end

        ST_COPY: begin
          if (w_at_last) begin
            r_state <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        ST_DONE: begin
          r_state <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // One address counter serves both the scan and the copy; the RAMs are
  // read combinationally so act_q already belongs to rd_addr.
  assign bus.rd_addr     = r_cnt;
  assign bus.ref_wr_en   = w_copy_wr;
  assign bus.ref_wr_addr = w_copy_wr ? r_cnt     : '0;
  assign bus.ref_wr_data = w_copy_wr ? bus.act_q : '0;

  assign bus.pix_valid = r_pix_valid;
  assign bus.pix_ref   = r_pix_ref;
  assign bus.pix_act   = r_pix_act;
  assign bus.pix_addr  = r_pix_addr;
  assign bus.pix_last  = r_pix_last;

  assign busy = state_is_busy(r_state);
  assign done = (r_state == ST_DONE);

  // Design invariants.
  a_wr_only_copy : assert property (@(posedge clk) disable iff (rst)
    bus.ref_wr_en |-> (r_state == ST_COPY));

  a_last_has_valid : assert property (@(posedge clk) disable iff (rst)
    r_pix_last |-> r_pix_valid);

  a_hold_on_stall : assert property (@(posedge clk) disable iff (rst)
    (r_pix_valid && !bus.pix_ready && !abort) |=>
      ($stable(r_pix_addr) && $stable(r_pix_ref) && $stable(r_pix_act) && r_pix_valid));

  a_done_single : assert property (@(posedge clk) disable iff (rst)
    done |=> !done);

endmodule

`default_nettype wire

// File: tb/tb_frame_pair_scheduler.sv
// ============================================================================
//  Module      : tb_frame_pair_scheduler
//  Description : Directed self-checking bench for frame_pair_scheduler with
//                behavioural ref/act frame RAMs.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_frame_pair_scheduler;

  import frame_pkg::*;

  logic clk      = 1'b0;
  logic rst      = 1'b1;
  logic start    = 1'b0;
  logic upd_en   = 1'b0;
  logic abort    = 1'b0;
  logic init_req = 1'b1;
  logic busy;
  logic done;

  int checks   = 0;
  int failures = 0;
  int wr_cnt   = 0;

  frame_pair_scheduler_if #(.AW(AW), .DW(DW)) bus ();

  frame_pair_scheduler #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .upd_en (upd_en),
    .abort  (abort),
    .busy   (busy),
    .done   (done),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] ref_init(input int i);
    return DW'(i + 'h5000);
  endfunction

  function automatic logic [DW-1:0] act_val(input int i);
    return DW'(i + 'h100);
  endfunction

  // Frame RAMs: act is a fixed pattern, ref is writable and re-initialisable.
  logic [DW-1:0] ref_mem [DEPTH];

  assign bus.ref_q = ref_mem[bus.rd_addr];
  assign bus.act_q = act_val(int'(bus.rd_addr));

  always @(posedge clk) begin
    if (init_req) begin
      for (int i = 0; i < DEPTH; i++) ref_mem[i] <= ref_init(i);
    end else if (bus.ref_wr_en === 1'b1) begin
      ref_mem[bus.ref_wr_addr] <= bus.ref_wr_data;
    end
  end

  always @(posedge clk) begin
    if (bus.ref_wr_en === 1'b1) wr_cnt <= wr_cnt + 1;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation still running, limit reached");
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1; init_req = 1'b1; start = 1'b0; abort = 1'b0; upd_en = 1'b0;
    bus.pix_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, bus.pix_valid, bus.pix_last, bus.ref_wr_en} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl: busy,done,valid,last,wr_en=%b want 00000",
               {busy, done, bus.pix_valid, bus.pix_last, bus.ref_wr_en});
    end
    checks++;
    if (bus.rd_addr !== '0 || bus.ref_wr_addr !== '0 || bus.pix_addr !== '0) begin
      failures++;
      $display("FAIL reset_addr: rd=%0d wr=%0d pix=%0d want 0 0 0",
               bus.rd_addr, bus.ref_wr_addr, bus.pix_addr);
    end
    checks++;
    if (bus.ref_wr_data !== '0 || bus.pix_ref !== '0 || bus.pix_act !== '0) begin
      failures++;
      $display("FAIL reset_data: wr_data=%h pix_ref=%h pix_act=%h want 0 0 0",
               bus.ref_wr_data, bus.pix_ref, bus.pix_act);
    end
    rst = 1'b0; init_req = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: busy=%b want 0 without start", busy);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_full_scan();
    int idx = 0, bad = 0, lastbad = 0, gaps = 0, done_cnt = 0;
    int done_cyc = -1, last_cyc = -1, first_cyc = -1, w0;
    bit finished = 1'b0;
    w0 = wr_cnt;
    bus.pix_ready = 1'b1; upd_en = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL scan_busy: busy=%b want 1 after start", busy);
    end
    for (int cyc = 0; cyc < 6000; cyc++) begin
      @(negedge clk);
      if (done === 1'b1) begin done_cnt++; done_cyc = cyc; end
      if (bus.pix_valid === 1'b1) begin
        if (bus.pix_addr !== AW'(idx) || bus.pix_ref !== ref_init(idx) ||
            bus.pix_act !== act_val(idx)) bad++;
        if (bus.pix_last !== (idx == DEPTH - 1)) lastbad++;
        if (last_cyc >= 0 && cyc != last_cyc + 1) gaps++;
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        idx++;
      end else if (bus.pix_last !== 1'b0) begin
        lastbad++;
      end
      if (busy !== 1'b1) begin finished = 1'b1; break; end
    end
    checks++;
    if (!finished) begin failures++; $display("FAIL scan_timeout: busy never dropped, want idle"); end
    checks++;
    if (first_cyc != 0) begin failures++; $display("FAIL scan_latency: first pair at cyc %0d want 0", first_cyc); end
    checks++;
    if (idx != DEPTH) begin failures++; $display("FAIL scan_count: got %0d pairs want %0d", idx, DEPTH); end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL scan_data: %0d bad pairs want 0", bad); end
    checks++;
    if (lastbad != 0) begin failures++; $display("FAIL scan_last: %0d bad pix_last cycles want 0", lastbad); end
    checks++;
    if (gaps != 0) begin failures++; $display("FAIL scan_gaps: %0d gaps want 0", gaps); end
    checks++;
    if (done_cnt != 1 || done_cyc != last_cyc + 1) begin
      failures++;
      $display("FAIL scan_done: pulses=%0d at cyc %0d want 1 at cyc %0d", done_cnt, done_cyc, last_cyc + 1);
    end
    checks++;
    if (wr_cnt != w0) begin failures++; $display("FAIL scan_nowrite: %0d writes want 0", wr_cnt - w0); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_stall();
    int idx = 0, bad = 0, unstable = 0, done_cnt = 0, stalls = 0;
    bit finished = 1'b0, prev_stall = 1'b0, r;
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [DW-1:0] sref = '0, sact = '0;
    logic [AW-1:0] saddr = '0, srd = '0;
    upd_en = 1'b0; start = 1'b1; bus.pix_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 20000; cyc++) begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
      if (prev_stall) begin
        if (bus.pix_valid !== 1'b1 || bus.pix_ref !== sref || bus.pix_act !== sact ||
            bus.pix_addr !== saddr || bus.rd_addr !== srd) unstable++;
      end
      if (busy !== 1'b1) begin finished = 1'b1; break; end
      r = pat[cyc % 4] ^ ($urandom_range(0, 3) == 0);
      bus.pix_ready = r;
      if (bus.pix_valid === 1'b1 && r) begin
        if (bus.pix_addr !== AW'(idx) || bus.pix_ref !== ref_init(idx) ||
            bus.pix_act !== act_val(idx)) bad++;
        idx++;
      end
      prev_stall = (bus.pix_valid === 1'b1) && !r;
      if (prev_stall) begin
        stalls++;
        sref = bus.pix_ref; sact = bus.pix_act; saddr = bus.pix_addr; srd = bus.rd_addr;
      end
    end
    bus.pix_ready = 1'b1;
    checks++;
    if (!finished) begin failures++; $display("FAIL stall_timeout: busy never dropped, want idle"); end
    checks++;
    if (idx != DEPTH) begin failures++; $display("FAIL stall_count: accepted %0d want %0d", idx, DEPTH); end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL stall_seq: %0d lost/duplicated/bad pairs want 0", bad); end
    checks++;
    if (unstable != 0 || stalls == 0) begin
      failures++;
      $display("FAIL stall_hold: %0d unstable of %0d stalls want 0 of >0", unstable, stalls);
    end
    checks++;
    if (done_cnt != 1) begin failures++; $display("FAIL stall_done: %0d pulses want 1", done_cnt); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_start_ignored();
    int idx = 0, bad = 0, done_cnt = 0, late_busy = 0, w0;
    bit finished = 1'b0;
    w0 = wr_cnt;
    bus.pix_ready = 1'b1; upd_en = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
      if (bus.pix_valid === 1'b1) begin
        if (bus.pix_addr !== AW'(idx) || bus.pix_act !== act_val(idx)) bad++;
        idx++;
      end
      if (busy !== 1'b1) begin finished = 1'b1; break; end
      // Pulse start mid-scan, in DRAIN and in DONE, each with upd_en=1.
      start  = (cyc == 100) || (cyc == 2000) || (bus.pix_last === 1'b1) || (done === 1'b1);
      upd_en = start;
    end
    start = 1'b0; upd_en = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0) late_busy++;
    end
    checks++;
    if (!finished || idx != DEPTH || bad != 0) begin
      failures++;
      $display("FAIL ign_scan: finished=%0d pairs=%0d bad=%0d want 1 %0d 0", finished, idx, bad, DEPTH);
    end
    checks++;
    if (done_cnt != 1) begin failures++; $display("FAIL ign_done: %0d pulses want 1", done_cnt); end
    checks++;
    if (wr_cnt != w0) begin failures++; $display("FAIL ign_nocopy: %0d writes want 0", wr_cnt - w0); end
    checks++;
    if (late_busy != 0) begin failures++; $display("FAIL ign_queued: %0d busy cycles after done want 0", late_busy); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_abort();
    bit found = 1'b0, got = 1'b0;
    int late = 0;
    bus.pix_ready = 1'b1; upd_en = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (bus.rd_addr === AW'(1234)) begin found = 1'b1; break; end
    end
    checks++;
    if (!found) begin failures++; $display("FAIL abort_reach: address 1234 not reached, want reached"); end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if ({busy, bus.pix_valid, done} !== 3'b000) begin
      failures++;
      $display("FAIL abort_idle: busy,valid,done=%b want 000", {busy, bus.pix_valid, done});
    end
    repeat (10) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) late++;
    end
    checks++;
    if (late != 0) begin failures++; $display("FAIL abort_nodone: %0d done/busy cycles want 0", late); end
    // start together with abort in IDLE must be swallowed
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL start_abort: busy=%b want 0", busy); end
    // a fresh start rescans from address 0
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      if (bus.pix_valid === 1'b1) begin got = 1'b1; break; end
    end
    checks++;
    if (!got || bus.pix_addr !== '0 || bus.pix_ref !== ref_init(0)) begin
      failures++;
      $display("FAIL abort_rescan: valid=%0d addr=%0d ref=%h want 1 0 %h", got, bus.pix_addr, bus.pix_ref, ref_init(0));
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    @(negedge clk);
  endtask

  // --------------------------------------------------------------------------
  task automatic test_rst_copy();
    bit found = 1'b0;
    int low_bad = 0, high_bad = 0, w0;
    init_req = 1'b1;
    @(negedge clk);
    init_req = 1'b0;
    w0 = wr_cnt;
    bus.pix_ready = 1'b1; upd_en = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; upd_en = 1'b0;
    for (int cyc = 0; cyc < 12000; cyc++) begin
      @(negedge clk);
      if (bus.ref_wr_en === 1'b1 && bus.ref_wr_addr === AW'(2000)) begin found = 1'b1; break; end
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (!found) begin failures++; $display("FAIL rstcp_reach: copy index 2000 not reached, want reached"); end
    checks++;
    if ({busy, done, bus.pix_valid, bus.pix_last, bus.ref_wr_en} !== 5'b0 ||
        bus.rd_addr !== '0 || bus.ref_wr_addr !== '0 || bus.pix_addr !== '0 ||
        bus.ref_wr_data !== '0 || bus.pix_ref !== '0 || bus.pix_act !== '0) begin
      failures++;
      $display("FAIL rstcp_outputs: ctrl=%b rd=%0d pix_addr=%0d pix_ref=%h want 00000 0 0 0",
               {busy, done, bus.pix_valid, bus.pix_last, bus.ref_wr_en},
               bus.rd_addr, bus.pix_addr, bus.pix_ref);
    end
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < DEPTH; i++) begin
      if (i < 2000) begin
        if (ref_mem[i] !== act_val(i)) low_bad++;
      end else begin
        if (ref_mem[i] !== ref_init(i)) high_bad++;
      end
    end
    checks++;
    if (low_bad != 0) begin failures++; $display("FAIL rstcp_low: %0d words below 2000 not copied want 0", low_bad); end
    checks++;
    if (high_bad != 0) begin failures++; $display("FAIL rstcp_high: %0d words from 2000 changed want 0", high_bad); end
    checks++;
    if (wr_cnt - w0 != 2000) begin failures++; $display("FAIL rstcp_writes: %0d writes want 2000", wr_cnt - w0); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_copy();
    int nwr = 0, first = -1, last = -1, seqbad = 0, done_cnt = 0, done_cyc = -1, mem_bad = 0;
    bit finished = 1'b0;
    init_req = 1'b1;
    @(negedge clk);
    init_req = 1'b0;
    bus.pix_ready = 1'b1; upd_en = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; upd_en = 1'b0;
    for (int cyc = 0; cyc < 15000; cyc++) begin
      @(negedge clk);
      if (done === 1'b1) begin done_cnt++; done_cyc = cyc; end
      if (bus.ref_wr_en === 1'b1) begin
        if (bus.ref_wr_addr !== AW'(nwr) || bus.rd_addr !== AW'(nwr) ||
            bus.ref_wr_data !== act_val(nwr)) seqbad++;
        if (first < 0) first = cyc;
        last = cyc;
        nwr++;
      end
      if (busy !== 1'b1) begin finished = 1'b1; break; end
    end
    @(negedge clk);
    for (int i = 0; i < DEPTH; i++) begin
      if (ref_mem[i] !== act_val(i)) mem_bad++;
    end
    checks++;
    if (!finished) begin failures++; $display("FAIL copy_timeout: busy never dropped, want idle"); end
    checks++;
    if (nwr != DEPTH || last - first + 1 != DEPTH) begin
      failures++;
      $display("FAIL copy_length: %0d writes over %0d cycles want %0d over %0d", nwr, last - first + 1, DEPTH, DEPTH);
    end
    checks++;
    if (seqbad != 0) begin failures++; $display("FAIL copy_seq: %0d bad write cycles want 0", seqbad); end
    checks++;
    if (done_cnt != 1 || done_cyc != last + 1) begin
      failures++;
      $display("FAIL copy_done: pulses=%0d at cyc %0d want 1 at cyc %0d", done_cnt, done_cyc, last + 1);
    end
    checks++;
    if (mem_bad != 0) begin failures++; $display("FAIL copy_mem: %0d ref words differ from i+0x100 want 0", mem_bad); end
  endtask

  // --------------------------------------------------------------------------
  initial begin
    bus.pix_ready = 1'b0;
    test_reset();
    test_full_scan();
    test_stall();
    test_start_ignored();
    test_abort();
    test_rst_copy();
    test_copy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/frame_pair_scheduler.md
FRAME_PAIR_SCHEDULER -- requirements
Module: frame_pair_scheduler

Interface
REQ-001 SHALL have parameter DEPTH, default 4800, meaning number of words per frame RAM (80x60 pixels).
REQ-002 SHALL have parameter AW, default 14, meaning address width.
REQ-003 SHALL have parameter DW, default 25, meaning word width.
REQ-004 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-005 SHALL have port rst  input  1  synchronous reset, active-high.
REQ-006 SHALL have port start  input  1  pulse; begins a scan when idle, ignored otherwise.
REQ-007 SHALL have port upd_en  input  1  sampled with start; 1 = copy act into ref after the scan.
REQ-008 SHALL have port abort  input  1  terminates any operation and returns to IDLE.
REQ-009 SHALL have port rd_addr  output  AW  shared combinational-read address for the ref and act RAMs.
REQ-010 SHALL have port ref_q  input  DW  ref RAM read data, valid in the same cycle as rd_addr.
REQ-011 SHALL have port act_q  input  DW  act RAM read data, valid in the same cycle as rd_addr.
REQ-012 SHALL have port ref_wr_addr  output  AW  ref RAM write address.
REQ-013 SHALL have port ref_wr_data  output  DW  ref RAM write data.
REQ-014 SHALL have port ref_wr_en  output  1  ref RAM write enable.
REQ-015 SHALL have port pix_valid  output  1  pixel pair available.
REQ-016 SHALL have port pix_ready  input  1  downstream accepts the pair.
REQ-017 SHALL have port pix_ref, pix_act  output  DW each  registered pixel pair.
REQ-018 SHALL have port pix_addr  output  AW  address of the current pair.
REQ-019 SHALL have port pix_last  output  1  high with the pair at address DEPTH-1.
REQ-020 SHALL have port busy  output  1  high in every state except IDLE.
REQ-021 SHALL have port done  output  1  one-cycle pulse at completion.

Function
REQ-022 SHALL implement states IDLE, SCAN, DRAIN, COPY and DONE.
REQ-023 In IDLE, start SHALL latch upd_en, clear the address counter and enter SCAN.
REQ-024 In SCAN, the output register SHALL load {ref_q, act_q, rd_addr} whenever pix_valid=0 or pix_ready=1, and the counter SHALL increment only on a load (one pair per cycle at full throughput, latency 1 cycle from address to pix_valid).
REQ-025 While pix_valid=1 and pix_ready=0, pix_* SHALL hold stable and rd_addr SHALL not advance.
REQ-026 The load at address DEPTH-1 SHALL cause a transition to DRAIN; the counter SHALL not wrap to 0 during SCAN.
REQ-027 DRAIN SHALL wait for acceptance of the last pair, then go to COPY if the latched upd_en=1, otherwise to DONE.
REQ-028 COPY SHALL drive rd_addr=i, ref_wr_addr=i, ref_wr_data=act_q and ref_wr_en=1 for i=0..DEPTH-1, one word per cycle with no stalls, then go to DONE.
REQ-029 ref_wr_en SHALL be 0 outside COPY.
REQ-030 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-031 abort SHALL take priority over every other transition: next state IDLE, pix_valid=0, ref_wr_en=0, and no done pulse; words already copied remain written.
REQ-032 A start arriving while busy=1 SHALL be ignored and SHALL not be queued.
REQ-033 Simultaneous start and abort in IDLE SHALL leave the block in IDLE.

Reset
REQ-034 On rst, the state SHALL become IDLE and the counter, rd_addr, ref_wr_addr, ref_wr_data, pix_ref, pix_act and pix_addr SHALL all become 0.
REQ-035 On rst, pix_valid, pix_last, ref_wr_en, busy and done SHALL all become 0, and the latched upd_en SHALL become 0.
REQ-036 rst asserted mid-SCAN or mid-COPY SHALL behave as abort and take precedence over it.

Structure
REQ-037 DEPTH, AW, DW and the state encoding SHALL live in the shared package frame_pkg.
REQ-038 The block SHALL be a single module containing the FSM, the address counter and the output register, with no sub-modules; the RAMs SHALL remain external.

Verification
REQ-039 The bench SHALL cover: start, upd_en=0, pix_ready=1 constant -> 4800 pairs at addresses 0..4799 on consecutive cycles, pix_last only at 4799, done exactly one cycle later, and no ref_wr_en.
REQ-040 The bench SHALL cover: pix_ready toggling 1,0,0,1 pseudo-randomly -> no pair lost or duplicated, and pix_ref/pix_act stable during every stall.
REQ-041 The bench SHALL cover: act filled with i+0x100, start with upd_en=1 -> after done, ref[i]=i+0x100 for all i, with COPY lasting exactly 4800 cycles.
REQ-042 The bench SHALL cover: abort at SCAN address 1234 -> IDLE next cycle, pix_valid=0, no done; a following start rescans from address 0.
REQ-043 The bench SHALL cover: rst in COPY at i=2000 -> ref[0..1999] updated, ref[2000..] unchanged, and all outputs at their reset values.
REQ-044 The bench SHALL cover: start pulsed during SCAN -> ignored, with exactly one done pulse produced.
